// File: rtl/vip_multi_sof_sync_generator.sv
// Multi-channel SOF generator: raster position counters, per-channel SOF
// pulses and clock dividers, and a lock FSM with acquisition count and
// grace period on loss of enable.
//
// state     | meaning
// UNLOCKED  | no valid timing, waiting for good
// ARMED     | timing good, counting ch0 matches toward lock
// LOCKED    | locked, timing good
// LOST      | timing lost, still reporting lock during grace period
module vip_multi_sof_sync_generator #(
  parameter int NUM_CH           = 2,
  parameter int NUMBER_OF_PLANES = 3,
  parameter int PLANES_PARALLEL  = 0,
  parameter int H_W              = 14,
  parameter int V_W              = 13,
  parameter int TOTALS_MINUS_ONE = 0,
  parameter int SOF_PULSE_CYCLES = 16,
  parameter int LOCK_FRAMES      = 2,
  parameter int UNLOCK_GRACE     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_enable,
  input  logic                  enable_count,
  input  logic                  hd_sdn,
  input  logic                  start_of_vsync,
  input  logic                  field_prediction,
  input  logic [H_W-1:0]        total_sample_count,
  input  logic                  total_sample_count_valid,
  input  logic [V_W-1:0]        total_line_count,
  input  logic                  total_line_count_valid,
  input  logic                  stable,
  input  logic                  output_enable,
  input  logic [NUM_CH*H_W-1:0] cfg_sof_sample,
  input  logic [NUM_CH*V_W-1:0] cfg_sof_line,
  input  logic [NUM_CH*2-1:0]   cfg_sof_subsample,
  input  logic [NUM_CH*2-1:0]   cfg_field_sel,
  input  logic [NUM_CH*H_W-1:0] cfg_divider,
  output logic [NUM_CH-1:0]     sof,
  output logic [NUM_CH-1:0]     div,
  output logic                  sof_locked,
  output logic [1:0]            lock_state
);

  localparam int SOF_W = $clog2(SOF_PULSE_CYCLES + 1);
  localparam int GR_W  = $clog2(UNLOCK_GRACE + 1);
  localparam logic [1:0] TICK_LAST = 2'(NUMBER_OF_PLANES - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_LOST     = 2'd3
  } lock_t;

  logic             en_nxt, vs0, enable, count, good;
  logic             enable_reg, field_reg;
  logic [1:0]       tick;
  logic [H_W-1:0]   h, h_last;
  logic [V_W-1:0]   v, v_last;
  logic             seq_mode, tick_wrap;
  logic [NUM_CH-1:0] match;

  assign en_nxt    = stable & total_sample_count_valid;
  assign vs0       = start_of_vsync & ~field_prediction;
  assign enable    = vs0 ? en_nxt : (en_nxt & enable_reg & ~clear_enable);
  assign count     = enable & enable_count;
  assign good      = enable & total_line_count_valid;
  assign h_last    = (TOTALS_MINUS_ONE != 0) ? total_sample_count : total_sample_count - H_W'(1);
  assign v_last    = (TOTALS_MINUS_ONE != 0) ? total_line_count : total_line_count - V_W'(1);
  assign seq_mode  = (PLANES_PARALLEL == 0) && !hd_sdn;
  assign tick_wrap = !seq_mode || (tick == TICK_LAST);

  // Enable history and field of the current frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_reg <= 1'b0;
      field_reg  <= 1'b0;
    end else begin
      enable_reg <= enable;
      if (start_of_vsync) field_reg <= field_prediction;
    end
  end

  // Raster position: subsample tick, sample and line, restarted by F0 vsync
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= '0;
      h    <= '0;
      v    <= '0;
    end else if (vs0) begin
      tick <= '0;
      h    <= '0;
      v    <= '0;
    end else if (count) begin
      if (tick_wrap) begin
        tick <= '0;
        if (h == h_last) begin
          h <= '0;
          v <= (v == v_last) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [H_W-1:0]   c_sample, c_div, dcnt;
    logic [V_W-1:0]   c_line;
    logic [1:0]       c_sub, c_sel;
    logic             field_ok, armed, div_r;
    logic [SOF_W-1:0] pulse_cnt;

    assign c_sample = cfg_sof_sample[i*H_W +: H_W];
    assign c_line   = cfg_sof_line[i*V_W +: V_W];
    assign c_sub    = cfg_sof_subsample[i*2 +: 2];
    assign c_sel    = cfg_field_sel[i*2 +: 2];
    assign c_div    = cfg_divider[i*H_W +: H_W];
    assign field_ok = (c_sel == 2'b00) | ((c_sel == 2'b01) & ~field_reg) |
                      ((c_sel == 2'b10) & field_reg);
    assign match[i] = count & (hd_sdn | (tick == c_sub)) & (h == c_sample) &
                      (v == c_line) & field_ok;
    assign sof[i]   = (pulse_cnt != '0);
    assign div[i]   = div_r;

    // SOF pulse: fixed-length, matches during an active pulse are dropped
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pulse_cnt <= '0;
      end else if (!output_enable) begin
        pulse_cnt <= '0;
      end else if (match[i] && pulse_cnt == '0) begin
        pulse_cnt <= SOF_W'(SOF_PULSE_CYCLES);
      end else if (pulse_cnt != '0) begin
        pulse_cnt <= pulse_cnt - 1'b1;
      end
    end

    // Divider: armed and phase-aligned by each match, counts counted ticks
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        armed <= 1'b0;
        dcnt  <= '0;
        div_r <= 1'b0;
      end else if (!output_enable || !enable) begin
        armed <= 1'b0;
        dcnt  <= '0;
        div_r <= 1'b0;
      end else if (match[i]) begin
        armed <= 1'b1;
        dcnt  <= '0;
        div_r <= 1'b0;
      end else begin
        div_r <= 1'b0;
        if (armed && count) begin
          if (dcnt == c_div) begin
            dcnt  <= '0;
            div_r <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
      end
    end
  end

  lock_t           state, state_nxt;
  logic [3:0]      match_cnt;
  logic [GR_W-1:0] grace_cnt;

  // Lock next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_UNLOCKED: if (good) state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (!good) state_nxt = ST_UNLOCKED;
        else if (match[0] && match_cnt == 4'(LOCK_FRAMES - 1)) state_nxt = ST_LOCKED;
      end
      ST_LOCKED: if (!good) state_nxt = ST_LOST;
      ST_LOST: begin
        if (good) state_nxt = ST_LOCKED;
        else if (grace_cnt == '0) state_nxt = ST_UNLOCKED;
      end
      default: state_nxt = ST_UNLOCKED;
    endcase
    if (!output_enable) state_nxt = ST_UNLOCKED;
  end

  // Lock state, acquisition count and grace down-counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_UNLOCKED;
      sof_locked <= 1'b0;
      match_cnt  <= '0;
      grace_cnt  <= GR_W'(UNLOCK_GRACE - 1);
    end else begin
      state      <= state_nxt;
      sof_locked <= (state_nxt == ST_LOCKED) || (state_nxt == ST_LOST);
      if (state != ST_ARMED) match_cnt <= '0;
      else if (match[0]) match_cnt <= match_cnt + 1'b1;
      if (state != ST_LOST) grace_cnt <= GR_W'(UNLOCK_GRACE - 1);
      else if (!good && grace_cnt != '0) grace_cnt <= grace_cnt - 1'b1;
    end
  end

  assign lock_state = state;

endmodule

// File: tb/tb_vip_multi_sof_sync_generator.sv
// Bench for vip_multi_sof_sync_generator: raster-position model plus
// directed frames covering SOF placement, dividers, field select, lock,
// pulse non-stretch, output_enable and async reset.
module tb_vip_multi_sof_sync_generator;
  localparam int NUM_CH = 2, H_W = 14, V_W = 13, PULSE = 16, LOCKF = 2, GRACE = 64;

  logic clk = 1'b0, rst = 1'b0;
  logic clear_enable = 0, enable_count = 1, hd_sdn = 0, start_of_vsync = 0, field_prediction = 0;
  logic [H_W-1:0] total_sample_count = 14'd100;
  logic [V_W-1:0] total_line_count = 13'd10;
  logic total_sample_count_valid = 1, total_line_count_valid = 1, stable = 1, output_enable = 1;
  logic [NUM_CH*H_W-1:0] cfg_sof_sample, cfg_divider;
  logic [NUM_CH*V_W-1:0] cfg_sof_line;
  logic [NUM_CH*2-1:0]   cfg_sof_subsample, cfg_field_sel;
  logic [NUM_CH-1:0] sof, div;
  logic sof_locked;
  logic [1:0] lock_state;

  vip_multi_sof_sync_generator #(
    .NUM_CH(NUM_CH), .NUMBER_OF_PLANES(3), .PLANES_PARALLEL(0), .H_W(H_W), .V_W(V_W),
    .TOTALS_MINUS_ONE(0), .SOF_PULSE_CYCLES(PULSE), .LOCK_FRAMES(LOCKF), .UNLOCK_GRACE(GRACE)
  ) dut (
    .clk(clk), .rst(rst), .clear_enable(clear_enable), .enable_count(enable_count),
    .hd_sdn(hd_sdn), .start_of_vsync(start_of_vsync), .field_prediction(field_prediction),
    .total_sample_count(total_sample_count), .total_sample_count_valid(total_sample_count_valid),
    .total_line_count(total_line_count), .total_line_count_valid(total_line_count_valid),
    .stable(stable), .output_enable(output_enable), .cfg_sof_sample(cfg_sof_sample),
    .cfg_sof_line(cfg_sof_line), .cfg_sof_subsample(cfg_sof_subsample),
    .cfg_field_sel(cfg_field_sel), .cfg_divider(cfg_divider), .sof(sof), .div(div),
    .sof_locked(sof_locked), .lock_state(lock_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int ecount = 0, E = 0, run0 = 0;
  bit chk_on = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Position is tracked as the number of counted ticks since the last F0
  // vsync; tick/sample/line are derived from it arithmetically.
  int m_pos = 0, m_edge = 0, m_state = 0, m_mc = 0, m_lost = 0;
  bit m_enreg = 0, m_field = 0;
  int m_last[NUM_CH] = '{-100000, -100000};
  bit m_armed[NUM_CH] = '{0, 0};
  int m_k[NUM_CH] = '{0, 0};
  logic [NUM_CH-1:0] exp_sof = '0, exp_div = '0;

  always @(posedge clk or posedge rst) begin : model
    int P, H, V, tk, hh, vv, sel;
    bit vs0, en, cnt, good, fok;
    bit mt[NUM_CH];
    if (rst) begin
      m_pos = 0; m_edge = 0; m_state = 0; m_mc = 0; m_lost = 0;
      m_enreg = 0; m_field = 0; exp_sof = '0; exp_div = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_last[i] = -100000; m_armed[i] = 0; m_k[i] = 0;
      end
    end else begin
      m_edge++;
      P = hd_sdn ? 1 : 3;
      H = int'(total_sample_count);
      V = int'(total_line_count);
      vs0 = start_of_vsync && !field_prediction;
      en = vs0 ? (stable && total_sample_count_valid)
               : (stable && total_sample_count_valid && m_enreg && !clear_enable);
      cnt = en && enable_count;
      good = en && total_line_count_valid;
      tk = m_pos % P;
      hh = (m_pos / P) % H;
      vv = (m_pos / (P * H)) % V;
      for (int i = 0; i < NUM_CH; i++) begin
        sel = int'(cfg_field_sel[i*2 +: 2]);
        fok = (sel == 0) || (sel == 1 && !m_field) || (sel == 2 && m_field);
        mt[i] = cnt && (hd_sdn || tk == int'(cfg_sof_subsample[i*2 +: 2])) &&
                hh == int'(cfg_sof_sample[i*H_W +: H_W]) &&
                vv == int'(cfg_sof_line[i*V_W +: V_W]) && fok;
      end
      if (vs0) m_pos = 0;
      else if (cnt) m_pos = (m_pos + 1) % (P * H * V);
      if (start_of_vsync) m_field = field_prediction;
      m_enreg = en;
      for (int i = 0; i < NUM_CH; i++) begin
        exp_div[i] = 1'b0;
        if (!output_enable) begin
          m_last[i] = m_edge - 100000;
          m_armed[i] = 0; m_k[i] = 0;
        end else begin
          if (mt[i] && !((m_edge - m_last[i]) >= 1 && (m_edge - m_last[i]) <= PULSE))
            m_last[i] = m_edge;
          if (!en) begin
            m_armed[i] = 0; m_k[i] = 0;
          end else if (mt[i]) begin
            m_armed[i] = 1; m_k[i] = 0;
          end else if (m_armed[i] && cnt) begin
            m_k[i]++;
            if (m_k[i] % (int'(cfg_divider[i*H_W +: H_W]) + 1) == 0) exp_div[i] = 1'b1;
          end
        end
        exp_sof[i] = output_enable && (m_edge - m_last[i]) >= 0 && (m_edge - m_last[i]) < PULSE;
      end
      if (!output_enable) m_state = 0;
      else case (m_state)
        0: if (good) begin m_state = 1; m_mc = 0; end
        1: if (!good) m_state = 0;
           else if (mt[0]) begin m_mc++; if (m_mc == LOCKF) m_state = 2; end
        2: if (!good) begin m_state = 3; m_lost = 0; end
        default: if (good) m_state = 2;
                 else begin m_lost++; if (m_lost == GRACE) m_state = 0; end
      endcase
    end
  end

  // Compare DUT against the model every cycle, plus a pulse-length bound
  always @(negedge clk) begin
    if (chk_on) begin
      check("sof", 32'(sof), 32'(exp_sof));
      check("div", 32'(div), 32'(exp_div));
      check("lock_state", 32'(lock_state), 32'(m_state));
      check("sof_locked", 32'(sof_locked), 32'(m_state >= 2));
      if (sof[0]) run0++;
      else begin
        if (run0 > 0) check("sof0_len_le_16", 32'(run0 <= PULSE), 32'd1);
        run0 = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1; ecount++;
  endtask
  task automatic goto(input int t);
    while (ecount < t) step();
  endtask
  task automatic vsync(input logic f);
    start_of_vsync = 1; field_prediction = f;
    step();
    start_of_vsync = 0; field_prediction = 0;
  endtask

  initial begin
    cfg_sof_sample    = {14'd50, 14'd5};
    cfg_sof_line      = {13'd7, 13'd2};
    cfg_sof_subsample = {2'd0, 2'd1};
    cfg_field_sel     = {2'b00, 2'b00};
    cfg_divider       = {14'd0, 14'd3};
    #1 rst = 1;
    #2;
    check("rst_sof", 32'(sof), 0);
    check("rst_div", 32'(div), 0);
    check("rst_lock_state", 32'(lock_state), 0);
    check("rst_sof_locked", 32'(sof_locked), 0);
    @(posedge clk); @(posedge clk); #1 rst = 0;
    chk_on = 1;
    step();
    check("no_lock_before_vs0", 32'(lock_state), 0);

    // Frame A: SOF placement and divider phase
    vsync(0); E = ecount;
    check("armed_after_vs0", 32'(lock_state), 1);
    goto(E + 616);  check("sof0_pre", 32'(sof[0]), 0);
    goto(E + 617);  check("sof0_rise", 32'(sof[0]), 1);
    goto(E + 620);  check("div0_pre", 32'(div[0]), 0);
    goto(E + 621);  check("div0_first", 32'(div[0]), 1);
    goto(E + 622);  check("div0_1clk", 32'(div[0]), 0);
    goto(E + 625);  check("div0_second", 32'(div[0]), 1);
    goto(E + 632);  check("sof0_last", 32'(sof[0]), 1);
    goto(E + 633);  check("sof0_fall", 32'(sof[0]), 0);
    goto(E + 2250); check("sof1_pre", 32'(sof[1]), 0);
    goto(E + 2251); check("sof1_rise", 32'(sof[1]), 1);
    goto(E + 2252); check("div1_every_tick", 32'(div[1]), 1);
    goto(E + 2999);

    // Frame B: second ch0 match locks; divider realigns
    vsync(0); E = ecount;
    goto(E + 616);  check("still_armed", 32'(lock_state), 1);
    goto(E + 617);  check("locked_2nd_sof", 32'(lock_state), 2);
    goto(E + 621);  check("div0_realigned", 32'(div[0]), 1);
    goto(E + 2999);

    // Frames C-E: field selection on ch1
    cfg_field_sel = {2'b10, 2'b00};
    vsync(1); E = ecount;
    goto(E + 617);  check("sof0_any_field", 32'(sof[0]), 1);
    goto(E + 2251); check("sof1_in_f1", 32'(sof[1]), 1);
    goto(E + 2999);
    vsync(0); E = ecount;
    goto(E + 2251); check("sof1_not_f0", 32'(sof[1]), 0);
    goto(E + 2999);
    cfg_field_sel = {2'b11, 2'b00};
    vsync(1); E = ecount;
    goto(E + 2251); check("sof1_disabled", 32'(sof[1]), 0);

    // Short loss of stable: LOST then relock at the next F0 vsync
    goto(E + 2989); stable = 0;
    goto(E + 2995);
    check("lost_state", 32'(lock_state), 3);
    check("lost_sof_locked", 32'(sof_locked), 1);
    goto(E + 2999); stable = 1;
    vsync(0); E = ecount;
    check("relocked", 32'(lock_state), 2);
    check("relocked_sof_locked", 32'(sof_locked), 1);

    // Long loss: grace expires
    goto(E + 2899); stable = 0;
    goto(E + 2999);
    check("grace_expired", 32'(lock_state), 0);
    check("grace_sof_locked", 32'(sof_locked), 0);
    stable = 1;
    vsync(0); E = ecount;
    check("rearmed", 32'(lock_state), 1);
    goto(E + 2999);

    // Short HD lines of 8 samples, ch0 at every line start
    total_sample_count = 14'd8; total_line_count = 13'd1; hd_sdn = 1;
    cfg_sof_sample = {14'd50, 14'd0}; cfg_sof_line = {13'd7, 13'd0};
    vsync(0); E = ecount;
    goto(E + 1);  check("hd_sof0_rise", 32'(sof[0]), 1);
    goto(E + 16); check("hd_sof0_last", 32'(sof[0]), 1);
    goto(E + 17); check("hd_no_stretch", 32'(sof[0]), 0);
    goto(E + 200);

    // output_enable drop mid-pulse, then async reset mid-pulse
    vsync(0); E = ecount;
    goto(E + 5); check("oe_pre_sof0", 32'(sof[0]), 1);
    output_enable = 0;
    step();
    check("oe_sof", 32'(sof), 0);
    check("oe_div", 32'(div), 0);
    check("oe_sof_locked", 32'(sof_locked), 0);
    check("oe_lock_state", 32'(lock_state), 0);
    output_enable = 1;
    goto(E + 12); check("pre_rst_sof0", 32'(sof[0]), 1);
    #2 rst = 1;
    #1;
    check("rst_now_sof", 32'(sof), 0);
    check("rst_now_div", 32'(div), 0);
    check("rst_now_locked", 32'(sof_locked), 0);
    check("rst_now_state", 32'(lock_state), 0);
    step(); rst = 0;
    repeat (50) step();
    check("no_relock_without_vs0", 32'(lock_state), 0);
    check("no_sof_without_vs0", 32'(sof[0]), 0);
    vsync(0);
    check("armed_after_f0", 32'(lock_state), 1);
    repeat (100) step();

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
